// File: rtl/sprite_pattern_arbiter_if.sv
// Request/return and pattern-memory signal bundle for sprite_pattern_arbiter.
// slave = arbiter side, master = sprite managers plus pattern memory.
interface sprite_pattern_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]    req_read;
    logic [NUM_REQ*13-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_gnt;
    logic [NUM_REQ-1:0]    req_avail;
    logic [DATA_W-1:0]     req_pattern;
    logic                  mem_read;
    logic [12:0]           mem_addr;
    logic [DATA_W-1:0]     mem_data;
    logic                  arb_idle;

    modport slave (
        input  req_read, req_addr, mem_data,
        output req_gnt, req_avail, req_pattern, mem_read, mem_addr, arb_idle
    );

    modport master (
        output req_read, req_addr, mem_data,
        input  req_gnt, req_avail, req_pattern, mem_read, mem_addr, arb_idle
    );
endinterface

// File: rtl/sprite_pattern_arbiter.sv
// Round-robin arbiter sharing one pattern-memory read port, with an ID tag pipe
// routing returns to their owner. Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority.
module sprite_pattern_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MEM_LATENCY = 2,
    parameter int DATA_W      = 32
) (
    input  logic                     clock,
    input  logic                     reset_l,
    input  logic                     clear,
    sprite_pattern_arbiter_if.slave  bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int AW   = 13;

    logic [ID_W-1:0]        r_ptr;
    logic [MEM_LATENCY-1:0] r_tag_vld;
    logic [ID_W-1:0]        r_tag_id [MEM_LATENCY];

    logic                   w_hit;
    logic [ID_W-1:0]        w_gnt_id;
    logic                   w_issue;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]        w_ptr_next;
    logic                   w_out_vld;
    logic [ID_W-1:0]        w_out_id;
    logic [NUM_REQ-1:0]     w_avail;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_hit    = 1'b0;
        w_gnt_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_read[rr_idx(r_ptr, k)]) begin
                w_hit    = 1'b1;
                w_gnt_id = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_issue = w_hit & ~clear & reset_l;

    always_comb begin
        w_gnt = '0;
        if (w_issue) w_gnt[w_gnt_id] = 1'b1;
    end

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    // Scan base stays at 0, which turns the search into lowest-index-wins.
    assign w_ptr_next = '0;
`else
    assign w_ptr_next = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_ptr     <= '0;
            r_tag_vld <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) r_tag_id[i] <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_gnt_id;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            if (clear) begin
                r_tag_vld <= '0;
                r_ptr     <= '0;
            end else if (w_issue) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // Returns landing in the clear cycle are dropped; later ones were never tagged valid.
    assign w_out_vld = r_tag_vld[MEM_LATENCY-1] & ~clear & reset_l;
    assign w_out_id  = r_tag_id[MEM_LATENCY-1];

    always_comb begin
        w_avail = '0;
        if (w_out_vld) w_avail[w_out_id] = 1'b1;
    end

    assign bus.req_gnt     = w_gnt;
    assign bus.mem_read    = w_issue;
    assign bus.mem_addr    = w_issue ? bus.req_addr[int'(w_gnt_id)*AW +: AW] : '0;
    assign bus.req_avail   = w_avail;
    assign bus.req_pattern = w_out_vld ? bus.mem_data : '0;
    assign bus.arb_idle    = ~reset_l | (~|bus.req_read & ~|r_tag_vld);

endmodule
